// File: rtl/if_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module  : if_fetch                                                     |
// | Purpose : instruction fetch, one outstanding imem request, one-entry   |
// |           output buffer feeding IF/ID, redirect with wrong-path drop   |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        if_valid
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic        r_valid;

  logic w_req;
  logic w_accept;
  logic w_load;
  logic w_consume;

  // A request may only issue when its response is guaranteed a free buffer slot.
  assign w_req     = rst && (r_state == S_REQ) && (!r_valid || !stall_in);
  assign w_accept  = w_req && imem_ready;
  assign w_load    = (r_state == S_WAIT) && imem_rvalid;
  assign w_consume = r_valid && !stall_in;

  assign imem_req  = w_req;
  assign imem_addr = r_fetch_pc;
  assign instr_out = r_instr;
  assign pc_out    = r_pc;
  assign if_valid  = r_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_REQ;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= 32'h0;
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_pc       <= 32'h0;
    end else if (redirect) begin
      r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      r_valid    <= 1'b0;
      r_instr    <= 32'h0;
      r_pc       <= 32'h0;
      // A request accepted now is wrong-path; its response must be swallowed.
      case (r_state)
        S_REQ:            r_state <= w_accept ? S_DISCARD : S_REQ;
        S_WAIT,
        S_DISCARD:        r_state <= imem_rvalid ? S_REQ : S_DISCARD;
        default:          r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_accept) begin
            r_req_pc <= r_fetch_pc;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_fetch_pc <= r_req_pc + 32'd4;
            r_state    <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid) r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase

      if (w_load) begin
        r_instr <= imem_rdata;
        r_pc    <= r_req_pc;
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_instr <= 32'h0;
        r_pc    <= 32'h0;
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
